// File: rtl/bus_op_sequencer_if.sv
// Bus/handshake bundle between the top-level controller and bus_op_sequencer.
interface bus_op_sequencer_if;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic [23:0] bus_ctrl;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
  logic        inc_pc, read;
  logic [4:0]  alu_op;
  logic        busy, done, mem_err;

  modport master (
    output start, mem_ready, ir,
    input  bus_ctrl, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in,
    input  inc_pc, read, alu_op, busy, done, mem_err
  );

  modport slave (
    input  start, mem_ready, ir,
    output bus_ctrl, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in,
    output inc_pc, read, alu_op, busy, done, mem_err
  );
endinterface

// File: rtl/bus_op_sequencer.sv
// Fetch/execute control sequencer and sole driver of the 24-source bus selects.
// Define MULDIV_SEQ_EN to sequence mul/div results through LO (T5) then HI (T6).
module bus_op_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned PC_IDX       = 20
) (
  input  logic              clock,
  input  logic              clear,
  bus_op_sequencer_if.slave bus
);
  localparam int unsigned CW = ($clog2(MEM_WAIT_MAX + 1) > 4) ? $clog2(MEM_WAIT_MAX + 1) : 4;

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

  typedef struct packed {
    logic [23:0] bus_ctrl;
    logic [15:0] reg_in;
    logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
    logic        inc_pc, read;
    logic [4:0]  alu_op;
    logic        busy, done;
  } out_t;

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt;
  logic          mem_err;
  logic          timeout, is_muldiv;
  out_t          out_q, out_d;
  logic [4:0]    op;
  logic [3:0]    ra, rb, rc;
  logic          unused_ir;

  assign op        = bus.ir[31:27];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign unused_ir = ^bus.ir[14:0];

`ifdef MULDIV_SEQ_EN
  assign is_muldiv = (op == 5'b01111) || (op == 5'b10000);
`else
  assign is_muldiv = 1'b0;
`endif

  assign timeout = (state == T1) && !bus.mem_ready && (wait_cnt == CW'(MEM_WAIT_MAX - 1));

  // Outputs are decoded from next_state and registered, so they line up with the state they belong to.
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
      out_q    <= '0;
    end else begin
      state    <= next_state;
      out_q    <= out_d;
      wait_cnt <= (state == T1) ? wait_cnt + CW'(1) : '0;
      if (timeout) mem_err <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = T0;
      T0:      next_state = T1;
      T1: begin
        if (bus.mem_ready)  next_state = T2;
        else if (timeout)   next_state = IDLE;
      end
      T2:      next_state = T3;
      T3:      next_state = T4;
      T4:      next_state = T5;
      T5:      next_state = is_muldiv ? T6 : IDLE;
      T6:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    out_d      = '0;
    out_d.busy = (next_state != IDLE);
    case (next_state)
      T0: begin
        out_d.bus_ctrl[PC_IDX] = 1'b1;
        out_d.mar_in           = 1'b1;
        out_d.inc_pc           = 1'b1;
        out_d.z_in             = 1'b1;
      end
      T1: begin
        out_d.bus_ctrl[19] = 1'b1;
        out_d.pc_in        = (state != T1);
        out_d.read         = 1'b1;
        out_d.mdr_in       = 1'b1;
      end
      T2: begin
        out_d.bus_ctrl[21] = 1'b1;
        out_d.ir_in        = 1'b1;
      end
      T3: begin
        out_d.bus_ctrl[rb] = 1'b1;
        out_d.y_in         = 1'b1;
      end
      T4: begin
        out_d.bus_ctrl[rc] = 1'b1;
        out_d.alu_op       = op;
        out_d.z_in         = 1'b1;
      end
      T5: begin
        out_d.bus_ctrl[19] = 1'b1;
        if (is_muldiv) out_d.lo_in = 1'b1;
        else           out_d.reg_in[ra] = 1'b1;
        out_d.done = !is_muldiv;
      end
      T6: begin
        out_d.bus_ctrl[18] = 1'b1;
        out_d.hi_in        = 1'b1;
        out_d.done         = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.bus_ctrl = out_q.bus_ctrl;
  assign bus.reg_in   = out_q.reg_in;
  assign bus.pc_in    = out_q.pc_in;
  assign bus.ir_in    = out_q.ir_in;
  assign bus.mar_in   = out_q.mar_in;
  assign bus.mdr_in   = out_q.mdr_in;
  assign bus.y_in     = out_q.y_in;
  assign bus.z_in     = out_q.z_in;
  assign bus.hi_in    = out_q.hi_in;
  assign bus.lo_in    = out_q.lo_in;
  assign bus.inc_pc   = out_q.inc_pc;
  assign bus.read     = out_q.read;
  assign bus.alu_op   = out_q.alu_op;
  assign bus.busy     = out_q.busy;
  assign bus.done     = out_q.done;
  assign bus.mem_err  = mem_err;
endmodule
